// File: rtl/mem_route_pkg.sv
// Shared types and defaults for the CPU data-port router.
package mem_route_pkg;

  typedef enum logic {
    SEL_RAM  = 1'b0,
    SEL_CONF = 1'b1
  } route_sel_t;

  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 4;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/data_route_ctrl_if.sv
// SRAM-like data port: request fields, address handshake and response.
interface data_route_ctrl_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/txn_tracker.sv
// Outstanding-transaction counter plus the target that owns the in-flight work.
module txn_tracker
  import mem_route_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  route_sel_t sel_in,
  output logic       empty,
  output logic       full,
  output route_sel_t cur_sel
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  route_sel_t       r_cur_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_cur_sel <= SEL_RAM;
    end else begin
      if (inc && !dec) begin
        r_cnt <= r_cnt + ONE;
      end else if (dec && !inc) begin
        r_cnt <= r_cnt - ONE;
      end
      // Owner only changes on the first accept after a drain; it is kept afterwards.
      if (inc && empty) begin
        r_cur_sel <= sel_in;
      end
    end
  end

  assign empty   = (r_cnt == '0);
  assign full    = (r_cnt == MAX_CNT);
  assign cur_sel = r_cur_sel;

endmodule

// File: rtl/data_route_ctrl.sv
// 1-to-2 data-port router; pins the route to the target owning in-flight
// transactions and flags responses that arrive from the wrong target.
module data_route_ctrl
  import mem_route_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              no_dcache,
  data_route_ctrl_if.slave  cpu,
  data_route_ctrl_if.master ram,
  data_route_ctrl_if.master conf,
  output logic              route_busy,
  output logic              err
);

  logic       w_empty;
  logic       w_full;
  route_sel_t w_cur_sel;
  route_sel_t w_sel_in;
  route_sel_t w_req_sel;
  logic       w_grant;
  logic       w_tgt_addr_ok;
  logic       w_accept;
  logic       w_cur_dok;
  logic       w_oth_dok;
  logic [31:0] w_cur_rdata;
  logic       w_resp;
  logic       w_err_evt;
  sram_req_t  w_fields;
  logic       r_err;

  txn_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_trk (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_accept),
    .dec    (w_resp),
    .sel_in (w_sel_in),
    .empty  (w_empty),
    .full   (w_full),
    .cur_sel(w_cur_sel)
  );

  assign w_sel_in  = route_sel_t'(no_dcache);
  assign w_req_sel = w_empty ? w_sel_in : w_cur_sel;
  // Switching target waits for a registered empty count, so the last data_ok
  // of the old target leaves a one-cycle bubble before the new one is granted.
  assign w_grant   = (w_empty || (w_sel_in == w_cur_sel)) && !w_full;
  assign w_fields  = '{wr: cpu.wr, size: cpu.size, addr: cpu.addr, wdata: cpu.wdata};

  always_comb begin
    ram.req       = 1'b0;
    ram.wr        = 1'b0;
    ram.size      = '0;
    ram.addr      = '0;
    ram.wdata     = '0;
    conf.req      = 1'b0;
    conf.wr       = 1'b0;
    conf.size     = '0;
    conf.addr     = '0;
    conf.wdata    = '0;
    w_tgt_addr_ok = 1'b0;
    if (w_req_sel == SEL_CONF) begin
      conf.req      = cpu.req & w_grant;
      conf.wr       = w_fields.wr;
      conf.size     = w_fields.size;
      conf.addr     = w_fields.addr;
      conf.wdata    = w_fields.wdata;
      w_tgt_addr_ok = conf.addr_ok;
    end else begin
      ram.req       = cpu.req & w_grant;
      ram.wr        = w_fields.wr;
      ram.size      = w_fields.size;
      ram.addr      = w_fields.addr;
      ram.wdata     = w_fields.wdata;
      w_tgt_addr_ok = ram.addr_ok;
    end
  end

  assign w_accept = w_grant & cpu.req & w_tgt_addr_ok;

  always_comb begin
    if (w_cur_sel == SEL_CONF) begin
      w_cur_dok   = conf.data_ok;
      w_oth_dok   = ram.data_ok;
      w_cur_rdata = conf.rdata;
    end else begin
      w_cur_dok   = ram.data_ok;
      w_oth_dok   = conf.data_ok;
      w_cur_rdata = ram.rdata;
    end
  end

  assign w_resp      = !w_empty & w_cur_dok;
  assign cpu.addr_ok = w_accept;
  assign cpu.data_ok = w_resp;
  assign cpu.rdata   = w_empty ? '0 : w_cur_rdata;

  assign w_err_evt = w_empty ? (ram.data_ok | conf.data_ok) : w_oth_dok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
    end
  end

  assign err        = r_err;
  assign route_busy = !w_empty;

endmodule

// File: tb/tb_data_route_ctrl.sv
// Directed bench for data_route_ctrl: forwarded responses go through a
// scoreboard queue, handshake/state checks are made inline.
module tb_data_route_ctrl;
  import mem_route_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic no_dcache = 1'b0;
  logic route_busy;
  logic err;

  data_route_ctrl_if cpu_if ();
  data_route_ctrl_if ram_if ();
  data_route_ctrl_if conf_if ();

  data_route_ctrl #(.MAX_OUTSTANDING(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .no_dcache (no_dcache),
    .cpu       (cpu_if),
    .ram       (ram_if),
    .conf      (conf_if),
    .route_busy(route_busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [31:0] cnt();
    return 32'(dut.u_trk.r_cnt);
  endfunction

  function automatic logic [31:0] cur_sel();
    return 32'(dut.u_trk.r_cur_sel);
  endfunction

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (!rst && cpu_if.data_ok === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_data_ok: got rdata %h, required no response", cpu_if.rdata);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", cpu_if.rdata, e);
      end
    end
  end

  initial begin
    cpu_if.req      = 1'b0;
    cpu_if.wr       = 1'b0;
    cpu_if.size     = 2'd2;
    cpu_if.addr     = '0;
    cpu_if.wdata    = '0;
    ram_if.addr_ok  = 1'b1;
    ram_if.data_ok  = 1'b0;
    ram_if.rdata    = '0;
    conf_if.addr_ok = 1'b1;
    conf_if.data_ok = 1'b0;
    conf_if.rdata   = '0;

    #2 rst = 1'b1;
    repeat (2) next();
    rst = 1'b0;
    mid();
    check("rst_cnt", cnt(), 0);
    check("rst_busy", 32'(route_busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_data_ok", 32'(cpu_if.data_ok), 0);

    // Cached read
    next();
    no_dcache = 1'b0; cpu_if.req = 1'b1; cpu_if.addr = 32'h100;
    mid();
    check("t1_addr_ok", 32'(cpu_if.addr_ok), 1);
    check("t1_ram_req", 32'(ram_if.req), 1);
    check("t1_conf_req", 32'(conf_if.req), 0);
    check("t1_ram_addr", ram_if.addr, 32'h100);
    next();
    cpu_if.req = 1'b0;
    check("t1_cnt1", cnt(), 1);
    check("t1_busy", 32'(route_busy), 1);
    next(); next();
    ram_if.data_ok = 1'b1; ram_if.rdata = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF);
    mid();
    check("t1_data_ok", 32'(cpu_if.data_ok), 1);
    next();
    ram_if.data_ok = 1'b0;
    check("t1_cnt0", cnt(), 0);

    // Switch stall
    cpu_if.req = 1'b1; cpu_if.addr = 32'h200;
    next();
    no_dcache = 1'b1; cpu_if.addr = 32'h300;
    mid();
    check("t2_stall_addr_ok", 32'(cpu_if.addr_ok), 0);
    check("t2_stall_conf_req", 32'(conf_if.req), 0);
    check("t2_stall_ram_req", 32'(ram_if.req), 0);
    next();
    ram_if.data_ok = 1'b1; ram_if.rdata = 32'h11111111; exp_q.push_back(32'h11111111);
    mid();
    check("t2_bubble_addr_ok", 32'(cpu_if.addr_ok), 0);
    check("t2_bubble_conf_req", 32'(conf_if.req), 0);
    next();
    ram_if.data_ok = 1'b0;
    mid();
    check("t2_conf_req", 32'(conf_if.req), 1);
    check("t2_addr_ok", 32'(cpu_if.addr_ok), 1);
    check("t2_conf_addr", conf_if.addr, 32'h300);
    next();
    cpu_if.req = 1'b0;
    check("t2_cur_sel", cur_sel(), 1);
    check("t2_cnt", cnt(), 1);
    conf_if.data_ok = 1'b1; conf_if.rdata = 32'hC0FFEE00; exp_q.push_back(32'hC0FFEE00);
    next();
    conf_if.data_ok = 1'b0;
    check("t2_cnt0", cnt(), 0);

    // Response with nothing outstanding
    conf_if.data_ok = 1'b1; conf_if.rdata = 32'h00000BAD;
    mid();
    check("e1_data_ok", 32'(cpu_if.data_ok), 0);
    check("e1_rdata", cpu_if.rdata, 0);
    next();
    conf_if.data_ok = 1'b0;
    check("e1_err", 32'(err), 1);
    next(); next();
    check("e1_err_sticky", 32'(err), 1);

    // Full
    no_dcache = 1'b0; cpu_if.req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_if.addr = 32'h1000 + 32'(i * 4);
      mid();
      check("full_fill_addr_ok", 32'(cpu_if.addr_ok), 1);
      next();
    end
    cpu_if.addr = 32'h1010;
    mid();
    check("full_addr_ok", 32'(cpu_if.addr_ok), 0);
    check("full_ram_req", 32'(ram_if.req), 0);
    check("full_cnt", cnt(), 4);
    next();
    ram_if.data_ok = 1'b1; ram_if.rdata = 32'hA0A0A0A0; exp_q.push_back(32'hA0A0A0A0);
    mid();
    check("full_resp_addr_ok", 32'(cpu_if.addr_ok), 0);
    next();
    ram_if.data_ok = 1'b0;
    check("full_cnt3", cnt(), 3);
    mid();
    check("full_reopen_addr_ok", 32'(cpu_if.addr_ok), 1);
    next();
    cpu_if.req = 1'b0;
    check("full_cnt4", cnt(), 4);

    // Drain to 2, then simultaneous accept and response
    ram_if.data_ok = 1'b1; ram_if.rdata = 32'hB1B1B1B1; exp_q.push_back(32'hB1B1B1B1);
    next();
    ram_if.rdata = 32'hB2B2B2B2; exp_q.push_back(32'hB2B2B2B2);
    next();
    ram_if.data_ok = 1'b0;
    check("sim_cnt2_pre", cnt(), 2);
    cpu_if.req = 1'b1; cpu_if.addr = 32'h2000;
    ram_if.data_ok = 1'b1; ram_if.rdata = 32'hB3B3B3B3; exp_q.push_back(32'hB3B3B3B3);
    mid();
    check("sim_addr_ok", 32'(cpu_if.addr_ok), 1);
    next();
    ram_if.data_ok = 1'b0;
    check("sim_cnt2", cnt(), 2);
    next();
    cpu_if.req = 1'b0;
    check("sim_cnt3", cnt(), 3);

    // Asynchronous reset mid-operation
    rst = 1'b1;
    #1;
    check("arst_cnt", cnt(), 0);
    check("arst_busy", 32'(route_busy), 0);
    check("arst_err", 32'(err), 0);
    next();
    rst = 1'b0;
    ram_if.data_ok = 1'b1; ram_if.rdata = 32'h00000005;
    mid();
    check("late_data_ok", 32'(cpu_if.data_ok), 0);
    next();
    ram_if.data_ok = 1'b0;
    check("late_err", 32'(err), 1);

    // Spurious response from the non-owning target
    rst = 1'b1;
    next();
    rst = 1'b0;
    check("e2_err_clear", 32'(err), 0);
    no_dcache = 1'b1; cpu_if.req = 1'b1; cpu_if.addr = 32'h400;
    next();
    cpu_if.req = 1'b0;
    check("e2_cnt1", cnt(), 1);
    check("e2_cur_sel", cur_sel(), 1);
    ram_if.data_ok = 1'b1; ram_if.rdata = 32'h00000066;
    mid();
    check("e2_not_fwd", 32'(cpu_if.data_ok), 0);
    next();
    ram_if.data_ok = 1'b0;
    check("e2_err", 32'(err), 1);
    conf_if.data_ok = 1'b1; conf_if.rdata = 32'h77777777; exp_q.push_back(32'h77777777);
    next();
    conf_if.data_ok = 1'b0;
    check("e2_cnt0", cnt(), 0);

    next();
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
